control_sequencer: RTL
======================

# control_sequencer

Parametrised next-generation instruction sequencer for the 6502-family core. It replaces the fixed-width, opcode-decoding FSM and sits between the external opcode decoder and the datapath, which holds the registers, ALU and address muxes. It is driven by a pre-decoded addressing-mode class rather than raw opcodes. New behaviour over the previous generation:
- memory wait-state handshake
- stack push/pull sequences
- maskable interrupt entry
- optional index page-crossing fix-up cycle

## Interface
Parameters:
- ADDR_W, 16, address bus width; sizes the vector constants.
- VEC_IRQ, 16'hFFFE, interrupt vector low-byte address; the high byte is at VEC_IRQ+1.
- STATE_W, 5, width of the `fsm` debug output; must hold every state code.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  4  addressing class from the decoder, sampled in FETCH: IMPL=0, ACC=1, IMM=2, ZP=3, ABS=4, IND_ZP=5, IND_ABS=6, BRANCH=7, PUSH=8, PULL=9; 10-15 behave as IMPL.
- is_store  in  1  current instruction writes memory; sampled in the last operand-read state.
- branch_valid  in  1  branch condition true; sampled in BR_CHECK.
- page_cross  in  1  ALU carry out of the indexed low-byte add; sampled in ABS1.
- irq_req  in  1  level interrupt request, already masked by the I flag.
- mem_ready  in  1  memory completes the current access this cycle.
- instruction_load, increment_pc, indirl_load, indirh_load, dirl_load, dirh_load, reg_load, branch_load  out  1 each  datapath strobes.
- sp_inc, sp_dec  out  1 each  stack pointer strobes.
- pc_vec_lo_load, pc_vec_hi_load  out  1 each  load one PC byte from the data bus.
- irq_ack  out  1  one-cycle pulse on entry to IRQ0.
- read_write  out  1  0 = read, 1 = write.
- address_select  out  3  PC=0, ZERO=1, ABS=2, IND_ZERO_0=3, IND_ZERO_1=4, IND_ABS_0=5, IND_ABS_1=6, STACK=7.
- alu_opsel  out  2  0 = EXEC (decoder op), 1 = ADR0, 2 = ADR1, 3 = PASS.
- fsm  out  STATE_W  current state code, for debug.

## Operation
- The FSM is Moore. Outputs are a pure function of state, except that every strobe is ANDed with mem_ready.
- FETCH priority: irq_req → IRQ0; otherwise dispatch on mode.
  - IMPL, ACC, IMM → EXEC.
  - ZP → ZP0, ZP1.
  - ABS → ABS0, ABS1, [ABS_FIX], ABS2.
  - IND_ZP → IZ0 to IZ3.
  - IND_ABS → IA0 to IA4.
  - BRANCH → BR_CHECK, then BR_GO if branch_valid, else FETCH.
  - PUSH → PUSH0.
  - PULL → PULL0, PULL1.
- Last operand state (ZP1, ABS2, IZ3, IA4): reg_load=1.
  - If is_store, go to STORE: read_write=1, with address_select held from the previous state.
  - Otherwise go to FETCH.
- EXEC: reg_load=1 for ACC/IMM and IMPL; increment_pc=1 for IMM only.
- Address-byte strobes match the previous generation:
  - ZP0, ABS0, IZ1, IA2: dirl_load.
  - ABS1, IZ2, IA3: dirh_load.
  - IZ0, IA0: indirl_load.
  - IA1: indirh_load.
- PC increments on FETCH, ZP0, ABS0, ABS1, IZ0, IA0, IA1, BR_CHECK.
- PUSH0: address_select=STACK, read_write=1, sp_dec=1.
- PULL0: sp_inc=1. PULL1: address_select=STACK, reg_load=1.
- Interrupt entry:
  - IRQ0 and IRQ1 write PCH then PCL; IRQ2 writes P. Each asserts read_write=1 and sp_dec.
  - IRQ3 reads VEC_IRQ and asserts pc_vec_lo_load.
  - IRQ4 reads VEC_IRQ+1 and asserts pc_vec_hi_load.
  - IRQ4 then goes to FETCH.
- irq_req is ignored in every state except FETCH. An interrupt never splits an instruction.

## Timing
- Reset: state=FETCH, fsm=0. While rst is high every strobe, irq_ack and read_write are forced to 0, with address_select=PC and alu_opsel=PASS.
- First fetch strobe occurs in the first cycle after rst falls.
- mem_ready=0 in any state:
  - state holds;
  - all strobes and irq_ack are 0;
  - address_select, read_write and alu_opsel hold.
- A stall on IRQ0 delays irq_ack until the cycle in which mem_ready=1.
- Latency with no wait states:
  - ZP load: 3 cycles; ZP store: 4.
  - ABS: 4, or 5 with the fix-up cycle.
  - IND_ZP: 5. IND_ABS: 6.
  - Branch: 2 not taken, 3 taken.
  - PUSH: 2. PULL: 3. IRQ entry: 6.
- rst asserted mid-sequence aborts immediately. No partial store completes after reset.

## Configuration
- CTRL_PAGE_FIX_EN defined: in ABS1 with page_cross=1 the FSM enters ABS_FIX for one extra cycle (dirh_load=1, alu_opsel=ADR1, no PC increment), then ABS2.
- CTRL_PAGE_FIX_EN undefined: page_cross is ignored, ABS_FIX is never entered, and the datapath must produce the full indexed address combinationally.

## Structure
- Package `cpu_pkg` holds:
  - mode, state, address_select and alu_opsel enums/constants;
  - read/write constants.
- Sub-module `strobe_decode`: combinational state → strobe map, instantiated once. The top level keeps the FSM register, the next-state logic and the mem_ready gating.

## Test plan
- Reset mid-IA2, release: fsm=0 on the first clock after release; instruction_load=1 while mem_ready=1; no write strobe during or after reset.
- ZP store (mode=3, is_store=1), mem_ready held 1: states FETCH, ZP0, ZP1, STORE, FETCH; read_write=1 only in STORE, with address_select=1.
- ABS load with page_cross=1:
  - with macro: 5 cycles, ABS_FIX dirh_load=1;
  - without macro: 4 cycles.
- irq_req=1 during an ABS2 stall (mem_ready=0 for 3 cycles):
  - instruction completes;
  - IRQ0 to IRQ4 follow, with irq_ack one cycle;
  - three write cycles with sp_dec, reading addresses VEC_IRQ and VEC_IRQ+1.
- Branch with branch_valid=0 then 1: 2 cycles then 3; branch_load pulses exactly once.
- PUSH then PULL back to back: sp_dec in PUSH0, sp_inc in PULL0, reg_load in PULL1; total 5 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types for the 6502-family control sequencer: addressing
//            classes, FSM state codes, address/ALU selects, read/write codes
//            and the datapath strobe bundle.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Pre-decoded addressing class; codes 10-15 are treated as IMPL.
  typedef enum logic [3:0] {
    MODE_IMPL    = 4'd0,
    MODE_ACC     = 4'd1,
    MODE_IMM     = 4'd2,
    MODE_ZP      = 4'd3,
    MODE_ABS     = 4'd4,
    MODE_IND_ZP  = 4'd5,
    MODE_IND_ABS = 4'd6,
    MODE_BRANCH  = 4'd7,
    MODE_PUSH    = 4'd8,
    MODE_PULL    = 4'd9
  } mode_e;

  // Sequencer state codes; FETCH must stay at zero.
  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_EXEC     = 5'd1,
    S_ZP0      = 5'd2,
    S_ZP1      = 5'd3,
    S_ABS0     = 5'd4,
    S_ABS1     = 5'd5,
    S_ABS_FIX  = 5'd6,
    S_ABS2     = 5'd7,
    S_IZ0      = 5'd8,
    S_IZ1      = 5'd9,
    S_IZ2      = 5'd10,
    S_IZ3      = 5'd11,
    S_IA0      = 5'd12,
    S_IA1      = 5'd13,
    S_IA2      = 5'd14,
    S_IA3      = 5'd15,
    S_IA4      = 5'd16,
    S_BR_CHECK = 5'd17,
    S_BR_GO    = 5'd18,
    S_PUSH0    = 5'd19,
    S_PULL0    = 5'd20,
    S_PULL1    = 5'd21,
    S_STORE    = 5'd22,
    S_IRQ0     = 5'd23,
    S_IRQ1     = 5'd24,
    S_IRQ2     = 5'd25,
    S_IRQ3     = 5'd26,
    S_IRQ4     = 5'd27
  } state_e;

  localparam int C_STATE_BITS = 5;

  // Datapath address source.
  typedef enum logic [2:0] {
    AS_PC         = 3'd0,
    AS_ZERO       = 3'd1,
    AS_ABS        = 3'd2,
    AS_IND_ZERO_0 = 3'd3,
    AS_IND_ZERO_1 = 3'd4,
    AS_IND_ABS_0  = 3'd5,
    AS_IND_ABS_1  = 3'd6,
    AS_STACK      = 3'd7
  } addr_sel_e;

  // ALU operand routing.
  typedef enum logic [1:0] {
    ALU_EXEC = 2'd0,
    ALU_ADR0 = 2'd1,
    ALU_ADR1 = 2'd2,
    ALU_PASS = 2'd3
  } alu_op_e;

  localparam logic C_RW_READ  = 1'b0;
  localparam logic C_RW_WRITE = 1'b1;

  // One-cycle datapath strobes; all of these are qualified by mem_ready.
  typedef struct packed {
    logic instruction_load;
    logic increment_pc;
    logic indirl_load;
    logic indirh_load;
    logic dirl_load;
    logic dirh_load;
    logic reg_load;
    logic branch_load;
    logic sp_inc;
    logic sp_dec;
    logic pc_vec_lo_load;
    logic pc_vec_hi_load;
    logic irq_ack;
  } strobes_t;

  // True for the final operand-read state of every memory addressing class.
  function automatic logic is_last_operand(input state_e s);
    return (s == S_ZP1) || (s == S_ABS2) || (s == S_IZ3) || (s == S_IA4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_decode.sv
`default_nettype none
// ============================================================================
// Module   : strobe_decode
// Brief    : Combinational state-to-output map of the control sequencer.
//            Produces raw (ungated) strobes plus address, ALU and R/W selects.
// Revision : 1.0 - initial release
// ============================================================================
module strobe_decode
  import cpu_pkg::*;
(
  input  state_e    state_i,
  input  logic      exec_imm_i,
  output strobes_t  strobes_o,
  output addr_sel_e addr_sel_o,
  output logic      rw_o,
  output alu_op_e   alu_op_o,
  output logic      vec_sel_o
);

  // Moore decode: every output depends only on the current state.
  always_comb begin
    strobes_o  = '0;
    addr_sel_o = AS_PC;
    rw_o       = C_RW_READ;
    alu_op_o   = ALU_PASS;
    vec_sel_o  = 1'b0;
    case (state_i)
      S_FETCH: begin
        strobes_o.instruction_load = 1'b1;
        strobes_o.increment_pc     = 1'b1;
      end
      S_EXEC: begin
        strobes_o.reg_load     = 1'b1;
        strobes_o.increment_pc = exec_imm_i;
        alu_op_o               = ALU_EXEC;
      end
      S_ZP0: begin
        strobes_o.increment_pc = 1'b1;
        strobes_o.dirl_load    = 1'b1;
      end
      S_ZP1: begin
        strobes_o.reg_load = 1'b1;
        addr_sel_o         = AS_ZERO;
      end
      S_ABS0: begin
        strobes_o.increment_pc = 1'b1;
        strobes_o.dirl_load    = 1'b1;
      end
      S_ABS1: begin
        strobes_o.increment_pc = 1'b1;
        strobes_o.dirh_load    = 1'b1;
        alu_op_o               = ALU_ADR0;
      end
      S_ABS_FIX: begin
        strobes_o.dirh_load = 1'b1;
        alu_op_o            = ALU_ADR1;
        addr_sel_o          = AS_ABS;
      end
      S_ABS2: begin
        strobes_o.reg_load = 1'b1;
        addr_sel_o         = AS_ABS;
      end
      S_IZ0: begin
        strobes_o.increment_pc = 1'b1;
        strobes_o.indirl_load  = 1'b1;
      end
      S_IZ1: begin
        strobes_o.dirl_load = 1'b1;
        addr_sel_o          = AS_IND_ZERO_0;
      end
      S_IZ2: begin
        strobes_o.dirh_load = 1'b1;
        addr_sel_o          = AS_IND_ZERO_1;
      end
      S_IZ3: begin
        strobes_o.reg_load = 1'b1;
        addr_sel_o         = AS_ABS;
      end
      S_IA0: begin
        strobes_o.increment_pc = 1'b1;
        strobes_o.indirl_load  = 1'b1;
      end
      S_IA1: begin
        strobes_o.increment_pc = 1'b1;
        strobes_o.indirh_load  = 1'b1;
      end
      S_IA2: begin
        strobes_o.dirl_load = 1'b1;
        addr_sel_o          = AS_IND_ABS_0;
      end
      S_IA3: begin
        strobes_o.dirh_load = 1'b1;
        addr_sel_o          = AS_IND_ABS_1;
      end
      S_IA4: begin
        strobes_o.reg_load = 1'b1;
        addr_sel_o         = AS_ABS;
      end
      S_BR_CHECK: strobes_o.increment_pc = 1'b1;
      S_BR_GO:    strobes_o.branch_load  = 1'b1;
      S_PUSH0: begin
        strobes_o.sp_dec = 1'b1;
        addr_sel_o       = AS_STACK;
        rw_o             = C_RW_WRITE;
      end
      S_PULL0: begin
        strobes_o.sp_inc = 1'b1;
        addr_sel_o       = AS_STACK;
      end
      S_PULL1: begin
        strobes_o.reg_load = 1'b1;
        addr_sel_o         = AS_STACK;
      end
      // Address for STORE is substituted by the top level from the held select.
      S_STORE: rw_o = C_RW_WRITE;
      S_IRQ0: begin
        strobes_o.sp_dec  = 1'b1;
        strobes_o.irq_ack = 1'b1;
        addr_sel_o        = AS_STACK;
        rw_o              = C_RW_WRITE;
      end
      S_IRQ1, S_IRQ2: begin
        strobes_o.sp_dec = 1'b1;
        addr_sel_o       = AS_STACK;
        rw_o             = C_RW_WRITE;
      end
      // Vector fetches: the datapath takes the address from vec_addr.
      S_IRQ3: begin
        strobes_o.pc_vec_lo_load = 1'b1;
        addr_sel_o               = AS_ABS;
        vec_sel_o                = 1'b1;
      end
      S_IRQ4: begin
        strobes_o.pc_vec_hi_load = 1'b1;
        addr_sel_o               = AS_ABS;
        vec_sel_o                = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Brief    : Moore instruction sequencer for the 6502-family core, driven by
//            a pre-decoded addressing class. Handles memory wait states,
//            stack push/pull, maskable interrupt entry and an optional index
//            page-crossing fix-up cycle (enabled by macro CTRL_PAGE_FIX_EN).
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] VEC_IRQ = 16'hFFFE,
  parameter int                STATE_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         mode,
  input  logic               is_store,
  input  logic               branch_valid,
  input  logic               page_cross,
  input  logic               irq_req,
  input  logic               mem_ready,
  output logic               instruction_load,
  output logic               increment_pc,
  output logic               indirl_load,
  output logic               indirh_load,
  output logic               dirl_load,
  output logic               dirh_load,
  output logic               reg_load,
  output logic               branch_load,
  output logic               sp_inc,
  output logic               sp_dec,
  output logic               pc_vec_lo_load,
  output logic               pc_vec_hi_load,
  output logic               irq_ack,
  output logic               read_write,
  output logic [2:0]         address_select,
  output logic [1:0]         alu_opsel,
  output logic               vec_sel,
  output logic [ADDR_W-1:0]  vec_addr,
  output logic [STATE_W-1:0] fsm
);

  localparam logic [ADDR_W-1:0] C_VEC_IRQ_HI = VEC_IRQ + ADDR_W'(1);

  state_e    state_q, state_d;
  logic      exec_imm_q, exec_imm_d;
  addr_sel_e store_addr_q, store_addr_d;

  strobes_t  w_dec_strobes;
  strobes_t  w_strobes;
  addr_sel_e w_dec_addr;
  logic      w_dec_rw;
  alu_op_e   w_dec_alu;
  logic      w_dec_vec_sel;
  logic      w_strobe_en;

`ifndef CTRL_PAGE_FIX_EN
  // Without the fix-up cycle the datapath forms the full indexed address itself.
  logic w_unused_page_cross;
  assign w_unused_page_cross = page_cross;
`endif

  // Next-state, IMM flag capture and store-address capture.
  always_comb begin
    state_d      = state_q;
    exec_imm_d   = exec_imm_q;
    store_addr_d = store_addr_q;
    if (state_q == S_FETCH) begin
      exec_imm_d = (mode == MODE_IMM);
    end
    // STORE reuses the address of the operand read that preceded it.
    if (is_last_operand(state_q)) begin
      store_addr_d = w_dec_addr;
    end
    case (state_q)
      S_FETCH: begin
        if (irq_req) begin
          state_d = S_IRQ0;
        end else begin
          case (mode_e'(mode))
            MODE_ZP:      state_d = S_ZP0;
            MODE_ABS:     state_d = S_ABS0;
            MODE_IND_ZP:  state_d = S_IZ0;
            MODE_IND_ABS: state_d = S_IA0;
            MODE_BRANCH:  state_d = S_BR_CHECK;
            MODE_PUSH:    state_d = S_PUSH0;
            MODE_PULL:    state_d = S_PULL0;
            default:      state_d = S_EXEC;
          endcase
        end
      end
      S_ZP0:  state_d = S_ZP1;
      S_ABS0: state_d = S_ABS1;
      S_ABS1: begin
`ifdef CTRL_PAGE_FIX_EN
        state_d = page_cross ? S_ABS_FIX : S_ABS2;
`else
        state_d = S_ABS2;
`endif
      end
      S_ABS_FIX:  state_d = S_ABS2;
      S_IZ0:      state_d = S_IZ1;
      S_IZ1:      state_d = S_IZ2;
      S_IZ2:      state_d = S_IZ3;
      S_IA0:      state_d = S_IA1;
      S_IA1:      state_d = S_IA2;
      S_IA2:      state_d = S_IA3;
      S_IA3:      state_d = S_IA4;
      S_ZP1, S_ABS2, S_IZ3, S_IA4:
                  state_d = is_store ? S_STORE : S_FETCH;
      S_BR_CHECK: state_d = branch_valid ? S_BR_GO : S_FETCH;
      S_PULL0:    state_d = S_PULL1;
      S_IRQ0:     state_d = S_IRQ1;
      S_IRQ1:     state_d = S_IRQ2;
      S_IRQ2:     state_d = S_IRQ3;
      S_IRQ3:     state_d = S_IRQ4;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; a wait state (mem_ready=0) freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      exec_imm_q   <= 1'b0;
      store_addr_q <= AS_PC;
    end else if (mem_ready) begin
      state_q      <= state_d;
      exec_imm_q   <= exec_imm_d;
      store_addr_q <= store_addr_d;
    end
  end

  strobe_decode u_strobe_decode (
    .state_i    (state_q),
    .exec_imm_i (exec_imm_q),
    .strobes_o  (w_dec_strobes),
    .addr_sel_o (w_dec_addr),
    .rw_o       (w_dec_rw),
    .alu_op_o   (w_dec_alu),
    .vec_sel_o  (w_dec_vec_sel)
  );

  // Strobes only fire when memory completes the access and never under reset.
  assign w_strobe_en = mem_ready & ~rst;
  assign w_strobes   = w_dec_strobes & {$bits(strobes_t){w_strobe_en}};

  assign instruction_load = w_strobes.instruction_load;
  assign increment_pc     = w_strobes.increment_pc;
  assign indirl_load      = w_strobes.indirl_load;
  assign indirh_load      = w_strobes.indirh_load;
  assign dirl_load        = w_strobes.dirl_load;
  assign dirh_load        = w_strobes.dirh_load;
  assign reg_load         = w_strobes.reg_load;
  assign branch_load      = w_strobes.branch_load;
  assign sp_inc           = w_strobes.sp_inc;
  assign sp_dec           = w_strobes.sp_dec;
  assign pc_vec_lo_load   = w_strobes.pc_vec_lo_load;
  assign pc_vec_hi_load   = w_strobes.pc_vec_hi_load;
  assign irq_ack          = w_strobes.irq_ack;

  assign read_write     = w_dec_rw & ~rst;
  assign address_select = rst ? AS_PC :
                          ((state_q == S_STORE) ? store_addr_q : w_dec_addr);
  assign alu_opsel      = rst ? ALU_PASS : w_dec_alu;
  assign vec_sel        = w_dec_vec_sel & ~rst;
  assign vec_addr       = ~vec_sel ? '0 :
                          ((state_q == S_IRQ4) ? C_VEC_IRQ_HI : VEC_IRQ);
  assign fsm            = STATE_W'(state_q);

endmodule
`default_nettype wire
